// File: rtl/bp_types.sv
// Branch-predictor helpers: counter reset value and saturating arithmetic for widths 1..4.
package bp_types;

    localparam int unsigned MaxCtrW = 4;

    typedef logic [MaxCtrW-1:0] ctr_t;

    function automatic ctr_t ctr_max(input int unsigned w);
        return ctr_t'((32'd1 << w) - 32'd1);
    endfunction

    // Weakly not-taken: 2**(w-1)-1, which is 0 for a 1-bit counter.
    function automatic ctr_t ctr_reset_val(input int unsigned w);
        return ctr_t'((32'd1 << (w - 1)) - 32'd1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t v, input int unsigned w);
        return (v == ctr_max(w)) ? v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I encoding constants used by the fetch-stage predictors.
package rv32i_types;

    localparam logic [6:0] op_br = 7'b1100011;

endpackage

// File: rtl/sat_ctr_table.sv
// Array of saturating counters with one combinational read port and one
// increment/decrement write port; reads return the pre-write value.
module sat_ctr_table
    import bp_types::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_inc
);

    localparam int unsigned Depth = 1 << IDX_W;
    localparam logic [CTR_W-1:0] RstVal = CTR_W'(ctr_reset_val(CTR_W));

    logic [CTR_W-1:0] ctr_q [Depth];
    logic [CTR_W-1:0] wr_val;
    ctr_t             wr_cur;
    ctr_t             wr_nxt;

    always_comb begin
        wr_cur = ctr_t'(ctr_q[wr_idx]);
        wr_nxt = wr_inc ? sat_inc(wr_cur, CTR_W) : sat_dec(wr_cur);
        wr_val = wr_nxt[CTR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                ctr_q[i] <= RstVal;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_val;
        end
    end

    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/gshare_pht.sv
// Gshare direction predictor: speculative GHR XOR PC indexes a saturating counter table.
// Define BP_STATS_EN to add the br_count / mis_count statistics outputs.
module gshare_pht
    import rv32i_types::*;
#(
    parameter int unsigned PHT_IDX = 4,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned GHR_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pred_valid,
    input  logic [31:0]        pred_pc,
    input  logic [6:0]         pred_opcode,
    output logic               pred_taken,
    output logic [PHT_IDX-1:0] pred_idx,
    output logic [GHR_W-1:0]   pred_ghr,
    input  logic               upd_valid,
    input  logic [PHT_IDX-1:0] upd_idx,
    input  logic [GHR_W-1:0]   upd_ghr,
    input  logic               upd_br_en,
    input  logic               upd_pred_taken,
`ifdef BP_STATS_EN
    output logic [31:0]        br_count,
    output logic [31:0]        mis_count,
`endif
    output logic               mis_predict
);

    logic               is_br;
    logic               mis;
    logic [CTR_W-1:0]   rd_ctr;
    logic [GHR_W-1:0]   ghr_q;
    logic [GHR_W-1:0]   ghr_d;
    logic [GHR_W-1:0]   spec_ghr;
    logic [GHR_W-1:0]   fix_ghr;
    logic               mis_predict_q;
    logic               unused_pc;

    assign unused_pc = ^{pred_pc[31:PHT_IDX+2], pred_pc[1:0]};

    assign is_br      = pred_valid && (pred_opcode == op_br);
    assign pred_idx   = pred_pc[PHT_IDX+1:2] ^ PHT_IDX'(ghr_q);
    assign pred_taken = is_br & rd_ctr[CTR_W-1];
    assign pred_ghr   = ghr_q;
    assign mis        = upd_valid && (upd_br_en != upd_pred_taken);

    sat_ctr_table #(
        .IDX_W (PHT_IDX),
        .CTR_W (CTR_W)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (pred_idx),
        .rd_ctr (rd_ctr),
        .wr_en  (upd_valid),
        .wr_idx (upd_idx),
        .wr_inc (upd_br_en)
    );

    if (GHR_W == 1) begin : g_ghr_one
        assign spec_ghr = pred_taken;
        assign fix_ghr  = upd_br_en;
    end else begin : g_ghr_shift
        assign spec_ghr = {ghr_q[GHR_W-2:0], pred_taken};
        assign fix_ghr  = {upd_ghr[GHR_W-2:0], upd_br_en};
    end

    // A mispredict squashes the fetched instruction, so its speculative shift is dropped.
    always_comb begin
        ghr_d = ghr_q;
        if (mis) begin
            ghr_d = fix_ghr;
        end else if (is_br) begin
            ghr_d = spec_ghr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q         <= '0;
            mis_predict_q <= 1'b0;
        end else begin
            ghr_q         <= ghr_d;
            mis_predict_q <= mis;
        end
    end

    assign mis_predict = mis_predict_q;

`ifdef BP_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] mis_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            if (upd_valid) br_count_q  <= br_count_q + 32'd1;
            if (mis)       mis_count_q <= mis_count_q + 32'd1;
        end
    end

    assign br_count  = br_count_q;
    assign mis_count = mis_count_q;
`endif

endmodule

// File: doc/gshare_pht.md
# gshare_pht

Parametrised gshare branch direction predictor that succeeds the fixed 4-bit-index pattern history table. It XORs a speculative global history register with PC bits to form the counter-table index. It uses configurable-width saturating counters and restores history on a misprediction. It sits in the fetch stage: prediction is combinational, and training arrives from the execute stage.

## Interface
- PHT_IDX, 4: log2 of the table depth; the table holds 2**PHT_IDX counters.
- CTR_W, 2: counter width in bits; legal range 1..4.
- GHR_W, 4: global history length; legal range 1..PHT_IDX.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pred_valid  in  1  a fetch-stage instruction is present.
- pred_pc  in  32  fetch PC.
- pred_opcode  in  7  opcode of the fetched instruction.
- pred_taken  out  1  predicted direction (combinational).
- pred_idx  out  PHT_IDX  table index used; carried down the pipeline.
- pred_ghr  out  GHR_W  GHR value before this branch's shift; carried down the pipeline.
- upd_valid  in  1  a branch resolved this cycle.
- upd_idx  in  PHT_IDX  the pred_idx carried with the resolved branch.
- upd_ghr  in  GHR_W  the pred_ghr carried with the resolved branch.
- upd_br_en  in  1  actual branch outcome.
- upd_pred_taken  in  1  the prediction that was made for this branch.
- mis_predict  out  1  registered misprediction flag, one cycle wide.

## Operation
- Branch qualifier: is_br = pred_valid && pred_opcode == op_br.
- Index: pred_idx = pred_pc[PHT_IDX+1:2] XOR zero-extended GHR.
- Prediction: pred_taken = is_br ? pht[pred_idx][CTR_W-1] : 0.
- Speculative history: when is_br is high, the GHR becomes {GHR[GHR_W-2:0], pred_taken} at the edge. When GHR_W = 1, the GHR becomes pred_taken.
- Training: when upd_valid is high, pht[upd_idx] increments if upd_br_en is high and decrements otherwise. Counters saturate at 2**CTR_W-1 and at 0, with no wrap-around.
- Mispredict: mis = upd_valid && (upd_br_en != upd_pred_taken).
  - On mis, the GHR loads {upd_ghr[GHR_W-2:0], upd_br_en}, the corrected history.
  - On mis, mis_predict is asserted the next cycle.
- Simultaneous is_br and mis: restore wins and the speculative shift is dropped, because the fetched instruction is on the wrong path.
- Simultaneous read and update of the same index: the read returns the pre-update value; there is no bypass.
- Non-branch opcodes: no GHR shift and pred_taken = 0. pred_idx and pred_ghr are still driven.
- Reset values:
  - Every counter is set to 2**(CTR_W-1)-1 (weakly not-taken; 0 when CTR_W = 1).
  - GHR = 0.
  - mis_predict = 0.
  - Statistics counters = 0.
- Reset mid-operation clears all state immediately; in-flight upd_* inputs are ignored while rst is low.

## Timing
- Prediction: zero-cycle combinational path from pred_pc and pred_opcode to pred_taken, pred_idx and pred_ghr.
- Training write: takes effect at the edge where upd_valid is high. A prediction in the following cycle sees the new value.
- mis_predict: high exactly one cycle after the resolving upd_valid cycle. Back-to-back mispredicts hold it high on consecutive cycles.
- GHR: restored GHR is used for indexing in the cycle after the mispredict.

## Configuration
- BP_STATS_EN defined: adds outputs br_count[31:0] and mis_count[31:0].
  - br_count increments on every upd_valid.
  - mis_count increments on every mis.
  - Both wrap modulo 2**32.
- BP_STATS_EN not defined: these ports and their registers do not exist; all other behaviour is identical.

## Structure
- rv32i_types holds the op_br constant (7'b1100011).
- A new package bp_types holds the reset-counter-value function and the saturate-increment/decrement functions, parameterised by width.
- Sub-module sat_ctr_table holds the counter array, the read port and the saturating write port. gshare_pht holds the GHR, index hashing, mispredict logic and statistics.

## Test plan
- Reset with PHT_IDX=4, CTR_W=2: every pht[i] = 1, GHR = 0, mis_predict = 0. Assert rst low mid-run and confirm the same state results.
- Repeated taken updates on idx 5: counter goes 1→2→3→3 (saturates). Subsequent predictions on idx 5 return taken. Not-taken updates bring it down to 0 and it stays at 0.
- Predict a branch at pc=0x10 with GHR=0b0011: pred_idx = 4 ^ 3 = 7. GHR becomes 0b0110 or 0b0111 depending on pred_taken. A non-branch opcode leaves GHR unchanged.
- Mispredict with upd_ghr=0b1010, upd_br_en=1, upd_pred_taken=0, while a branch predicts in the same cycle: GHR = 0b0101 and mis_predict = 1 one cycle later.
- Same-cycle update and read of the same index: the read shows the old counter; the next-cycle read shows the new one.
- BP_STATS_EN defined, 10 updates with 3 mispredicts: br_count = 10 and mis_count = 3. Preload mis_count to 0xFFFFFFFF, force one more mispredict, and confirm it wraps to 0.
